// File: rtl/ram_window_arbiter_if.sv
// ram_window_arbiter_if: bus bundle between the slot path, the background
// requester, the SRAM/ROM pins and the window arbiter.
//   slave  : arbiter side (timing inputs, requests in; memory pins, ack out)
//   master : environment side (slot decode, background engine, pin model)
interface ram_window_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 8
);
  logic          PHI1;
  logic          cpu_sel;
  logic          cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic          bg_req;
  logic          bg_we;
  logic [AW-1:0] bg_addr;
  logic [DW-1:0] bg_wdata;
  logic          bg_ack;
  logic [DW-1:0] bg_rdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_doe;
  logic          mem_cs;
  logic          mem_oe_n;
  logic          mem_we_n;
  logic          dben;
  logic [2:0]    phase;

  modport slave (
    input  PHI1, cpu_sel, cpu_rw, cpu_addr,
    input  bg_req, bg_we, bg_addr, bg_wdata, mem_rdata,
    output bg_ack, bg_rdata, mem_addr, mem_wdata, mem_doe,
    output mem_cs, mem_oe_n, mem_we_n, dben, phase
  );

  modport master (
    output PHI1, cpu_sel, cpu_rw, cpu_addr,
    output bg_req, bg_we, bg_addr, bg_wdata, mem_rdata,
    input  bg_ack, bg_rdata, mem_addr, mem_wdata, mem_doe,
    input  mem_cs, mem_oe_n, mem_we_n, dben, phase
  );
endinterface

// File: rtl/ram_window_arbiter.sv
// ram_window_arbiter: time-slices the shared SRAM/ROM pins between the Apple II
// slot path (S4-S7, PHI0) and one background requester (S1-S3, PHI1).
// Ports:
//   C7M  : 7 MHz bus clock, all state on rising edge
//   nRES : asynchronous active-low reset
//   bus  : ram_window_arbiter_if.slave (PHI1, slot request, background
//          request/ack/data, memory pins, dben, phase)
module ram_window_arbiter #(
  parameter int AW = 20,
  parameter int DW = 8
) (
  input logic                  C7M,
  input logic                  nRES,
  ram_window_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    BG_IDLE,
    BG_ADDR,
    BG_STRB,
    BG_CAPT
  } bg_state_e;

  logic [2:0]    s_q, s_d;
  logic          phi1_q, phi1_d;
  logic          phi0_seen_q, phi0_seen_d;
  bg_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          bg_cs_q, bg_cs_d;
  logic          bg_oe_n_q, bg_oe_n_d;
  logic          bg_we_n_q, bg_we_n_d;
  logic          bg_doe_q, bg_doe_d;
  logic          dben_q, dben_d;
  logic          cs_en_q, cs_en_d;

  logic          resync;
  logic          s1_next;
  logic          bg_idle;
  logic          slot_sel;

  always_comb begin
    phi1_d      = bus.PHI1;
    phi0_seen_d = phi0_seen_q | ~bus.PHI1;
    resync      = bus.PHI1 & ~phi1_q & phi0_seen_q;

    // S0 (no PHI0 yet) and S7 (stretched cycle) hold until the next PHI1 rise
    if (resync) begin
      s_d = 3'd1;
    end else if ((s_q == 3'd0) || (s_q == 3'd7)) begin
      s_d = s_q;
    end else begin
      s_d = s_q + 3'd1;
    end
    s1_next = (s_d == 3'd1);

    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;

    // A PHI1 resync always restarts the FSM: an in-flight STRB/CAPT is
    // abandoned without ack and a still-pending request is re-granted at once.
    if (s1_next) begin
      if (bus.bg_req) begin
        state_d = BG_ADDR;
        addr_d  = bus.bg_addr;
        we_d    = bus.bg_we;
        wdata_d = bus.bg_wdata;
      end else begin
        state_d = BG_IDLE;
      end
    end else begin
      unique case (state_q)
        BG_ADDR: state_d = BG_STRB;
        BG_STRB: state_d = BG_CAPT;
        BG_CAPT: begin
          state_d = BG_IDLE;
          ack_d   = 1'b1;
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end
        end
        default: state_d = BG_IDLE;
      endcase
    end

    // Background strobes are registered from the next state
    bg_cs_d   = (state_d == BG_STRB) || (state_d == BG_CAPT);
    bg_oe_n_d = ~(bg_cs_d & ~we_d);
    bg_we_n_d = ~((state_d == BG_STRB) & we_d);
    bg_doe_d  = (state_d != BG_IDLE) & we_d;

    dben_d  = s_q[2];
    cs_en_d = ((s_q == 3'd4) & bus.cpu_rw) | (s_q >= 3'd5);
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      s_q         <= '0;
      phi1_q      <= 1'b0;
      phi0_seen_q <= 1'b0;
      state_q     <= BG_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      bg_cs_q     <= 1'b0;
      bg_oe_n_q   <= 1'b1;
      bg_we_n_q   <= 1'b1;
      bg_doe_q    <= 1'b0;
      dben_q      <= 1'b0;
      cs_en_q     <= 1'b0;
    end else begin
      s_q         <= s_d;
      phi1_q      <= phi1_d;
      phi0_seen_q <= phi0_seen_d;
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      bg_cs_q     <= bg_cs_d;
      bg_oe_n_q   <= bg_oe_n_d;
      bg_we_n_q   <= bg_we_n_d;
      bg_doe_q    <= bg_doe_d;
      dben_q      <= dben_d;
      cs_en_q     <= cs_en_d;
    end
  end

  assign bg_idle  = (state_q == BG_IDLE);
  assign slot_sel = bg_idle & bus.cpu_sel & cs_en_q;

  assign bus.mem_addr  = bg_idle ? bus.cpu_addr : addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_doe   = bg_doe_q;
  assign bus.mem_cs    = bg_cs_q | slot_sel;
  assign bus.mem_oe_n  = bg_oe_n_q & ~(slot_sel & bus.cpu_rw);
  assign bus.mem_we_n  = bg_we_n_q & ~(slot_sel & ~bus.cpu_rw);
  assign bus.bg_ack    = ack_q;
  assign bus.bg_rdata  = rdata_q;
  assign bus.dben      = dben_q;
  assign bus.phase     = s_q;

endmodule
